// File: rtl/psum_store_stage_pkg.sv
// rtl/psum_store_stage_pkg.sv - shared widths, types and FSM states for the psum store stage
package psum_store_stage_pkg;

  localparam int PEROW      = 4;
  localparam int PSUMDWD    = 16;
  localparam int PPADADDRWD = 6;
  localparam int PASSWD     = 4;

  typedef logic [PEROW-1:0][PSUMDWD-1:0] psum_vec_t;

  // Pad write control, laid out the same way the pad controller expects it
  typedef struct packed {
    logic [PPADADDRWD-1:0] waddr;
    logic                  write;
  } ppctl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WORK,
    ST_STALL
  } state_t;

endpackage

// File: rtl/psum_store_stage_if.sv
// rtl/psum_store_stage_if.sv - MAC/PIN operand channels and SS/OUT result channels
interface psum_store_stage_if;
  import psum_store_stage_pkg::*;

  logic                  MAC_rdy;
  logic                  MAC_ack;
  psum_vec_t             i_Psum_MAC;
  logic                  PIN_rdy;
  logic                  PIN_ack;
  psum_vec_t             i_Psum_PIN;
  logic                  SS_rdy;
  logic                  SS_ack;
  logic [PPADADDRWD-1:0] o_ss_waddr;
  logic                  o_ss_write;
  psum_vec_t             o_Psum_SS;
  logic                  OUT_rdy;
  logic                  OUT_ack;
  psum_vec_t             o_Psum_OUT;

  modport master (
    input  MAC_rdy, i_Psum_MAC, PIN_rdy, i_Psum_PIN, SS_ack, OUT_ack,
    output MAC_ack, PIN_ack, SS_rdy, o_ss_waddr, o_ss_write, o_Psum_SS,
           OUT_rdy, o_Psum_OUT
  );

  modport slave (
    output MAC_rdy, i_Psum_MAC, PIN_rdy, i_Psum_PIN, SS_ack, OUT_ack,
    input  MAC_ack, PIN_ack, SS_rdy, o_ss_waddr, o_ss_write, o_Psum_SS,
           OUT_rdy, o_Psum_OUT
  );

endinterface

// File: rtl/psum_lane_adder.sv
// rtl/psum_lane_adder.sv - lane-wise wrapping psum adder, read-back operand forced to zero on pass 0
module psum_lane_adder
  import psum_store_stage_pkg::*;
(
  input  psum_vec_t mac,
  input  psum_vec_t pin,
  input  logic      zero_pin,
  output psum_vec_t sum
);

  // Each lane wraps modulo 2^PSUMDWD; no saturation
  always_comb begin
    sum = '0;
    for (int l = 0; l < PEROW; l++) begin
      sum[l] = mac[l] + (zero_pin ? {PSUMDWD{1'b0}} : pin[l]);
    end
  end

endmodule

// File: rtl/psum_store_stage.sv
// rtl/psum_store_stage.sv - accumulates MAC psums into the pad, emitting the final pass on OUT
module psum_store_stage
  import psum_store_stage_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic                  i_inst_reset,
  input  logic                  i_inst_stall,
  input  logic [PPADADDRWD:0]   i_size,
  input  logic [PASSWD-1:0]     i_npass,
  psum_store_stage_if.master    bus,
  output logic                  o_done
);

  state_t                state, state_nxt;
  logic                  full;
  logic                  to_out;
  logic                  last_loaded;
  logic                  done;
  logic [PPADADDRWD-1:0] idx;
  logic [PPADADDRWD-1:0] waddr;
  logic [PASSWD-1:0]     pass;
  logic [PASSWD-1:0]     npass_r;
  logic [PPADADDRWD:0]   size_r;
  psum_vec_t             data;
  psum_vec_t             sum;
  ppctl_t                ss_ctl;

  logic pass0, operands_ok, ss_xfer, out_xfer, xfer, load;
  logic idx_last, pass_last, finish;

  assign pass0       = (pass == '0);
  assign operands_ok = bus.MAC_rdy && (pass0 || bus.PIN_rdy);
  assign ss_xfer     = full && !to_out && bus.SS_ack;
  assign out_xfer    = full && to_out && bus.OUT_ack;
  assign xfer        = ss_xfer || out_xfer;
  // The register refills in the same cycle its pending entry drains
  assign load        = (state == ST_WORK) && !i_inst_reset && !i_inst_stall &&
                       !last_loaded && operands_ok && (!full || xfer);
  assign idx_last    = ({1'b0, idx} == (size_r - 1'b1));
  assign pass_last   = (pass == (npass_r - 1'b1));
  // Once the final entry is in the register, its OUT transfer ends the job
  assign finish      = last_loaded && out_xfer && !i_inst_reset;

  psum_lane_adder u_adder (
    .mac      (bus.i_Psum_MAC),
    .pin      (bus.i_Psum_PIN),
    .zero_pin (pass0),
    .sum      (sum)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state: instruction reset dominates stall and completion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_WORK;
      ST_WORK: begin
        if (i_inst_reset)      state_nxt = ST_IDLE;
        else if (finish)       state_nxt = ST_IDLE;
        else if (i_inst_stall) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (i_inst_reset)       state_nxt = ST_IDLE;
        else if (finish)        state_nxt = ST_IDLE;
        else if (!i_inst_stall) state_nxt = ST_WORK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Data register, routing flag and the idx/pass loop counters
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      full        <= 1'b0;
      to_out      <= 1'b0;
      last_loaded <= 1'b0;
      done        <= 1'b0;
      idx         <= '0;
      pass        <= '0;
      waddr       <= '0;
      size_r      <= '0;
      npass_r     <= '0;
      data        <= '0;
    end else begin
      done <= finish;
      if (state == ST_IDLE) begin
        if (i_start) begin
          size_r      <= i_size;
          npass_r     <= i_npass;
          idx         <= '0;
          pass        <= '0;
          last_loaded <= 1'b0;
          full        <= 1'b0;
        end
      end else if (i_inst_reset) begin
        full <= 1'b0;
      end else if (load) begin
        full   <= 1'b1;
        data   <= sum;
        to_out <= pass_last;
        if (!pass_last) waddr <= idx;
        if (idx_last) begin
          idx         <= '0;
          pass        <= pass + 1'b1;
          last_loaded <= pass_last;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (xfer) begin
        full <= 1'b0;
      end
    end
  end

  assign ss_ctl.write   = full && !to_out;
  assign ss_ctl.waddr   = waddr;

  assign bus.MAC_ack    = load;
  assign bus.PIN_ack    = load && !pass0;
  assign bus.SS_rdy     = ss_ctl.write;
  assign bus.o_ss_write = ss_ctl.write;
  assign bus.o_ss_waddr = ss_ctl.waddr;
  assign bus.o_Psum_SS  = data;
  assign bus.OUT_rdy    = full && to_out;
  assign bus.o_Psum_OUT = data;
  assign o_done         = done;

endmodule

// File: tb/tb_psum_store_stage.sv
// tb/tb_psum_store_stage.sv - job table with scoreboard plus hand sequences for stall, abort and reset
module tb_psum_store_stage;
  import psum_store_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rstn, start, inst_reset, inst_stall, done;
  logic [6:0] size;
  logic [3:0] npass;

  psum_store_stage_if bus();

  psum_store_stage dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_inst_reset (inst_reset),
    .i_inst_stall (inst_stall),
    .i_size       (size),
    .i_npass      (npass),
    .bus          (bus.master),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          size;
    int          npass;
    logic [15:0] mac_p0;
    logic [15:0] mac_pn;
    logic [15:0] step;
    bit          rnd;
    int          exp_out;
    int          exp_ss;
  } job_t;

  typedef struct {
    logic       is_out;
    logic [5:0] waddr;
    psum_vec_t  data;
  } exp_t;

  exp_t      sb[$];
  psum_vec_t pad_model [64];
  job_t      jobs [7];
  int        n_cmp = 0;
  int        n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic psum_vec_t mkvec(input logic [15:0] base, input logic [15:0] step);
    psum_vec_t v;
    for (int l = 0; l < PEROW; l++) v[l] = base + step * 16'(l);
    return v;
  endfunction

  function automatic psum_vec_t addvec(input psum_vec_t a, input psum_vec_t b);
    psum_vec_t v;
    for (int l = 0; l < PEROW; l++) v[l] = a[l] + b[l];
    return v;
  endfunction

  task automatic idle_inputs();
    start = 0; inst_reset = 0; inst_stall = 0;
    bus.MAC_rdy = 0; bus.PIN_rdy = 0; bus.SS_ack = 0; bus.OUT_ack = 0;
    bus.i_Psum_MAC = '0; bus.i_Psum_PIN = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ss_rdy"},  bus.SS_rdy, 0);
    chk({tag, "_out_rdy"}, bus.OUT_rdy, 0);
    chk({tag, "_mac_ack"}, bus.MAC_ack, 0);
    chk({tag, "_pin_ack"}, bus.PIN_ack, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_waddr"},   bus.o_ss_waddr, 0);
    chk({tag, "_data"},    bus.o_Psum_SS, 0);
  endtask

  task automatic run_job(input job_t j, input int id);
    int        bidx = 0, bpass = 0, n_out = 0, n_ss = 0, cyc = 0, last_out = -10;
    bit        got_done = 0, all_loaded = 0, mrdy, prdy;
    logic [15:0] base;
    exp_t      e;
    psum_vec_t pin_v, exp_v;
    for (int i = 0; i < 64; i++) pad_model[i] = '0;
    sb.delete();
    @(posedge clk); #1;
    start = 1; size = 7'(j.size); npass = 4'(j.npass);
    @(posedge clk); #1;
    start = 0;
    while (!got_done && cyc < 3000) begin
      mrdy = j.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      prdy = j.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      base = (bpass == 0) ? j.mac_p0 : j.mac_pn;
      if (j.rnd) base = base + 16'(bidx);
      pin_v = (bpass == 0) ? {$urandom, $urandom} : pad_model[bidx];
      bus.MAC_rdy = mrdy; bus.i_Psum_MAC = mkvec(base, j.step);
      bus.PIN_rdy = prdy; bus.i_Psum_PIN = pin_v;
      bus.SS_ack  = j.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.OUT_ack = j.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      chk("ss_write_eq_rdy", bus.o_ss_write, bus.SS_rdy);
      chk("rdy_exclusive", bus.SS_rdy & bus.OUT_rdy, 0);
      if (bus.SS_rdy && bus.SS_ack) begin
        chk("sb_nonempty_ss", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ss_route", 0, e.is_out);
          chk("ss_waddr", bus.o_ss_waddr, e.waddr);
          chk("ss_data", bus.o_Psum_SS, e.data);
        end
        n_ss++;
      end
      if (bus.OUT_rdy && bus.OUT_ack) begin
        chk("sb_nonempty_out", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_route", 1, e.is_out);
          chk("out_data", bus.o_Psum_OUT, e.data);
        end
        n_out++;
        last_out = cyc;
      end
      chk("pin_ack", bus.PIN_ack, bus.MAC_ack && (bpass != 0));
      if (bus.MAC_ack) begin
        chk("mac_ack_needs_rdy", mrdy, 1);
        chk("mac_ack_after_last", all_loaded, 0);
        exp_v = addvec(bus.i_Psum_MAC, (bpass == 0) ? psum_vec_t'('0) : pin_v);
        e.is_out = (bpass == j.npass - 1);
        e.waddr  = 6'(bidx);
        e.data   = exp_v;
        sb.push_back(e);
        pad_model[bidx] = exp_v;
        if (bidx == j.size - 1 && bpass == j.npass - 1) all_loaded = 1;
        if (bidx == j.size - 1) begin bidx = 0; bpass++; end
        else bidx++;
      end
      if (done) begin
        got_done = 1;
        chk("done_latency", cyc - last_out, 1);
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (!got_done) $display("FAIL job%0d_timeout: got no done expected done", id);
    chk("job_done_seen", got_done, 1);
    chk("job_out_count", n_out, j.exp_out);
    chk("job_ss_count", n_ss, j.exp_ss);
    chk("job_sb_empty", sb.size(), 0);
    idle_inputs();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_no_rdy", bus.SS_rdy | bus.OUT_rdy, 0);
  endtask

  psum_vec_t held;

  initial begin
    idle_inputs();
    rstn = 0; size = 0; npass = 0;
    jobs[0] = '{3,  1, 16'h0001, 16'h0000, 16'h0001, 1'b0, 3,  0};
    jobs[1] = '{2,  2, 16'h0005, 16'h0007, 16'h0000, 1'b0, 2,  2};
    jobs[2] = '{1,  3, 16'h0100, 16'h0011, 16'h0003, 1'b1, 1,  2};
    jobs[3] = '{4,  3, 16'h1234, 16'h0F0F, 16'h1111, 1'b1, 4,  8};
    jobs[4] = '{1,  2, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 1,  1};
    jobs[5] = '{64, 2, 16'h8000, 16'h9000, 16'h4321, 1'b1, 64, 64};
    jobs[6] = '{2, 15, 16'h0003, 16'h0101, 16'h0007, 1'b1, 2,  28};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1;

    for (int k = 0; k < 7; k++) run_job(jobs[k], k);

    // Backpressure on OUT: data holds, no loads, then back-to-back refill on ack
    @(posedge clk); #1;
    start = 1; size = 7'd2; npass = 4'd1;
    bus.MAC_rdy = 1; bus.i_Psum_MAC = mkvec(16'h00A0, 16'h0001);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("bp_first_load", bus.MAC_ack, 1);
    @(posedge clk); #1;
    bus.i_Psum_MAC = mkvec(16'h0B00, 16'h0010);
    held = mkvec(16'h00A0, 16'h0001);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_out_rdy", bus.OUT_rdy, 1);
      chk("bp_data_stable", bus.o_Psum_OUT, held);
      chk("bp_no_load", bus.MAC_ack, 0);
      @(posedge clk); #1;
    end
    bus.OUT_ack = 1;
    @(negedge clk);
    chk("bp_refill_same_cycle", bus.MAC_ack, 1);
    @(posedge clk); #1;
    bus.MAC_rdy = 0;
    @(negedge clk);
    chk("bp_second_out", bus.o_Psum_OUT, mkvec(16'h0B00, 16'h0010));
    chk("bp_second_rdy", bus.OUT_rdy, 1);
    @(posedge clk); #1;
    bus.OUT_ack = 0;
    @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_drained", bus.OUT_rdy, 0);

    // Stall with SS pending, then instruction reset, restart and sync reset
    @(posedge clk); #1;
    start = 1; size = 7'd4; npass = 4'd2;
    bus.MAC_rdy = 1; bus.i_Psum_MAC = mkvec(16'h0003, 16'h0000);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("st_load0", bus.MAC_ack, 1);
    @(posedge clk); #1;
    inst_stall = 1;
    @(negedge clk);
    chk("st_ss_pending", bus.SS_rdy, 1);
    chk("st_waddr0", bus.o_ss_waddr, 0);
    @(posedge clk); #1;
    bus.SS_ack = 1;
    @(negedge clk);
    chk("st_ss_held", bus.SS_rdy, 1);
    chk("st_no_load_xfer", bus.MAC_ack, 0);
    @(posedge clk); #1;
    bus.SS_ack = 0;
    @(negedge clk);
    chk("st_ss_done", bus.SS_rdy, 0);
    chk("st_no_load_empty", bus.MAC_ack, 0);
    @(posedge clk); #1;
    inst_stall = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_resume_load", bus.MAC_ack, 1);
    @(posedge clk); #1;
    inst_reset = 1;
    @(negedge clk);
    chk("ir_ss_pending", bus.SS_rdy, 1);
    chk("ir_waddr1", bus.o_ss_waddr, 1);
    chk("ir_no_load", bus.MAC_ack, 0);
    @(posedge clk); #1;
    inst_reset = 0;
    @(negedge clk);
    chk("ir_ss_dropped", bus.SS_rdy, 0);
    chk("ir_idle_no_load", bus.MAC_ack, 0);
    chk("ir_no_done", done, 0);
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("rs_load", bus.MAC_ack, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_ss_rdy", bus.SS_rdy, 1);
    chk("rs_waddr0", bus.o_ss_waddr, 0);
    @(posedge clk); #1;
    rstn = 0;
    @(negedge clk);
    chk("sr_before_edge", bus.SS_rdy, 1);
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    check_all_zero("sync_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
